// File: rtl/scan_pkg.sv
// Shared types and default chain geometry for the scan-chain loader.
// The default chain is 15 memory bytes, one button bit, 7 LED bits and a 16-bit key.
package scan_pkg;

  localparam int BYTE_W            = 8;
  localparam int MEM_BITS          = 120;
  localparam int IO_BITS           = 8;
  localparam int KEY_BITS          = 16;
  localparam int CHAIN_LEN_DEFAULT = MEM_BITS + IO_BITS + KEY_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/scan_chain_loader_if.sv
// Host-side byte streams of the loader: write bytes in, captured readback bytes out.
interface scan_chain_loader_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [scan_pkg::BYTE_W-1:0] in_data;
  logic                       out_valid;
  logic [scan_pkg::BYTE_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/scan_byte_serdes.sv
// One-byte serialiser/deserialiser: shifts a loaded byte out LSB first while
// capturing the returning serial bits into the same bit positions.
module scan_byte_serdes
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  input  logic [3:0]        nshift,
  input  logic              shift,
  input  logic              ser_in,
  output logic              next_bit,
  output logic              last,
  output logic [BYTE_W-1:0] cap_next
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] cap_q, cap_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        nshift_q, nshift_d;

  // NOTE: every _d gets its hold value first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    shreg_d  = shreg_q;
    cap_d    = cap_q;
    idx_d    = idx_q;
    nshift_d = nshift_q;
    if (load) begin
      shreg_d  = data;
      cap_d    = '0;
      idx_d    = '0;
      nshift_d = nshift;
    end else if (shift) begin
      shreg_d      = shreg_q >> 1;
      cap_d[idx_q] = ser_in;
      idx_d        = idx_q + 3'd1;
    end
  end

  // Capture bits beyond nshift are never written, so they stay at the zero set on load.
  assign next_bit = shreg_d[0];
  assign last     = ({1'b0, idx_q} == (nshift_q - 4'd1));
  assign cap_next = cap_d;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      cap_q    <= '0;
      idx_q    <= '0;
      nshift_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
      nshift_q <= nshift_d;
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Scan-chain loader: streams host bytes onto scan_in, returns the displaced chain
// bits as readback bytes, and holds the CPU halted while a load is in flight.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  scan_chain_loader_if.slave  host,
  output logic                scan_enable,
  output logic                scan_in,
  input  logic                scan_out,
  output logic                busy,
  output logic                cpu_halt,
  output logic                done
);

  localparam logic [CNT_WIDTH-1:0] LEN       = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] BYTE_BITS = CNT_WIDTH'(BYTE_W);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] bits_left_q, bits_left_d;
  logic                 scan_enable_q, scan_enable_d;
  logic                 scan_in_q, scan_in_d;
  logic                 out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]    out_data_q, out_data_d;

  logic                 accept;
  logic                 shifting;
  logic [3:0]           nshift;
  logic                 ser_next;
  logic                 ser_last;
  logic [BYTE_W-1:0]    cap_next;

  // abort wins over a byte offered in the same cycle.
  assign accept   = (state_q == LOAD) && host.in_valid && !abort;
  assign shifting = (state_q == SHIFT);
  assign nshift   = (bits_left_q >= BYTE_BITS) ? 4'd8 : 4'(bits_left_q);

  scan_byte_serdes u_serdes (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .data     (host.in_data),
    .nshift   (nshift),
    .shift    (shifting),
    .ser_in   (scan_out),
    .next_bit (ser_next),
    .last     (ser_last),
    .cap_next (cap_next)
  );

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bits_left_d = LEN;
        end
      end
      LOAD: begin
        if (abort)              state_d = IDLE;
        else if (host.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        bits_left_d = bits_left_q - ONE;
        if (abort) begin
          state_d = IDLE;
        end else if (ser_last) begin
          out_valid_d = 1'b1;
          out_data_d  = cap_next;
          state_d     = (bits_left_q == ONE) ? DONE : LOAD;
        end
      end
      DONE: state_d = IDLE;
    endcase
    // scan_enable/scan_in are registered from the next state so they move together.
    scan_enable_d = (state_d == SHIFT);
    scan_in_d     = scan_enable_d & ser_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bits_left_q   <= '0;
      scan_enable_q <= 1'b0;
      scan_in_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      bits_left_q   <= bits_left_d;
      scan_enable_q <= scan_enable_d;
      scan_in_q     <= scan_in_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  assign host.in_ready  = (state_q == LOAD) && !abort;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign scan_enable    = scan_enable_q;
  assign scan_in        = scan_in_q;
  assign busy           = (state_q == LOAD) || (state_q == SHIFT);
  assign cpu_halt       = busy;
  assign done           = (state_q == DONE);

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Upstream driver of the memory/IO/key scan chain.
- Accepts a byte stream over a valid/ready handshake and serialises it onto scan_in with exact per-bit scan_enable pulses.
- Captures the bits falling out of scan_out into readback bytes, so a host can load the program and locking key and read back the previous chain contents in one pass.
- Holds the CPU halted while a load is in progress.

Parameters:
- CHAIN_LEN, 144, total scan-chain bits to shift per load (15x8 memory + 1 button + 7 LED + 16 key); must be >= 1.
- CNT_WIDTH, 8, width of the chain bit counter; must satisfy 2^CNT_WIDTH > CHAIN_LEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  ends a load early; honoured in LOAD/SHIFT.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte; shifted LSB first.
- in_ready  output  1  loader accepts a byte this cycle.
- out_valid  output  1  one-cycle pulse: out_data holds a captured byte.
- out_data  output  8  captured chain bits, first-out bit in bit 0.
- scan_enable  output  1  chain shifts on the next edge when high.
- scan_in  output  1  serial bit into the chain head.
- scan_out  input  1  serial bit from the chain tail.
- busy  output  1  high in LOAD and SHIFT.
- cpu_halt  output  1  equals busy; stalls the core during loading.
- done  output  1  one-cycle pulse when a full CHAIN_LEN bits have been shifted.

Behaviour:
- Reset values:
  - state=IDLE.
  - in_ready, out_valid, scan_enable, scan_in, busy, cpu_halt and done are all 0.
  - out_data=0; counters=0.
- Reset mid-operation: return to IDLE next edge; no further scan_enable pulse; partial chain contents are left as-is.
- States:
  - IDLE: start=1 -> LOAD; bits_left=CHAIN_LEN.
  - LOAD: in_ready=1. On in_valid && in_ready, latch in_data into shreg, set nshift=min(8, bits_left), go to SHIFT. No timeout.
  - SHIFT: scan_enable=1 and scan_in=shreg[0] every cycle.
    - Each cycle: shreg>>=1; capture scan_out into cap[j], where j=cycle index 0..nshift-1; bits_left--.
    - After nshift cycles: out_data<=cap, with bits >= nshift forced to 0; out_valid pulses in the following cycle.
    - Then go to LOAD if bits_left>0, else DONE.
  - DONE: done=1 for one cycle -> IDLE.
- scan_enable and scan_in are registered outputs and change together.
- Exactly CHAIN_LEN scan_enable cycles occur per completed load; never more.
- Throughput: after a byte is accepted, 8 SHIFT cycles, then in_ready in the next cycle. With in_valid held high, a new byte is accepted every 9 cycles.
- Partial last byte: when CHAIN_LEN mod 8 = r != 0, only bits [r-1:0] of the last byte are shifted; upper bits are ignored.
- abort:
  - In LOAD, or in SHIFT on any cycle, scan_enable drops the next cycle and state goes to IDLE.
  - No out_valid for the incomplete byte; no done.
  - abort takes priority over byte acceptance in the same cycle.
- start while busy is ignored. start and abort together in IDLE: abort ignored, load starts.
- in_data ordering: the first byte sent ends up deepest in the chain (key register end).

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - BYTE_W=8;
  - default chain-length constants MEM_BITS=120, IO_BITS=8, KEY_BITS=16 and CHAIN_LEN_DEFAULT.
- One natural sub-module, scan_byte_serdes: 8-bit parallel-in shift-out plus serial-in capture with a shift count.
- The FSM and bit counter stay in the top module.

Test Plan:
- CHAIN_LEN=144; start; send 18 bytes 0x00..0x11 back-to-back.
  - Exactly 144 scan_enable cycles; done pulses once; 18 out_valid pulses.
  - A second identical load reads back bytes 0x00..0x11 in order.
- CHAIN_LEN=20; start; send 0xFF, 0xA5, 0xF3.
  - Third byte shifts 4 cycles (scan_in 1,1,0,0); total 20 enables.
  - Third out_data has bits [7:4]=0.
- Serial order: byte 0x01 in LOAD -> scan_in over 8 shift cycles = 1,0,0,0,0,0,0,0; in_ready returns high 9 cycles after acceptance.
- abort asserted in the 3rd SHIFT cycle of byte 2 -> scan_enable 0 the next cycle, busy=0, no out_valid for byte 2, no done.
- rst asserted mid-SHIFT, then start again -> all outputs 0 after the reset edge; the fresh load again takes exactly CHAIN_LEN enables.
- start pulsed during LOAD, and in_valid asserted in IDLE -> both ignored: in_ready stays 0 in IDLE, and the bit count is unchanged.
